simd_mc_feeder: RTL and testbench

SIMD_MC_FEEDER -- requirements
Module: simd_mc_feeder

---
 rtl/simd_pkg.sv | 30 +++
 rtl/simd_pair_fifo.sv | 50 +++++
 rtl/simd_mc_feeder.sv | 116 +++++++++++
 tb/tb_simd_mc_feeder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/simd_pkg.sv
// Shared types and constants for the SIMD memory-controller feeder.
// Holds the burst FSM states, operand widths and opcode encodings.
package simd_pkg;

  localparam int OPW   = 128;
  localparam int LANE  = 32;
  localparam int LANES = OPW / LANE;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_MAC = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_STREAM,
    S_FINISH
  } state_t;

  typedef struct packed {
    logic [OPW-1:0] opa;
    logic [OPW-1:0] opb;
  } pair_t;

endpackage

// File: rtl/simd_pair_fifo.sv
// Operand-pair FIFO: power-of-two depth, wrapping pointers, occupancy count.
// Pushes while full are dropped; pops while empty are ignored.
module simd_pair_fifo
  import simd_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  pair_t      push_data,
  input  logic       pop,
  output pair_t      pop_data,
  output logic       full,
  output logic       empty,
  output logic [5:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [5:0] DEPTH_C = 6'(DEPTH);

  pair_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           push_ok;
  logic           pop_ok;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == 6'd0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {5'd0, push_ok} - {5'd0, pop_ok};
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/simd_mc_feeder.sv
// Buffers host operand pairs and replays them to the SIMD core as bursts:
// instruction lead-in, one registered beat per cycle, then a done pulse.
module simd_mc_feeder
  import simd_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int LEAD  = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wr_en,
  input  logic [OPW-1:0] wr_opa,
  input  logic [OPW-1:0] wr_opb,
  output logic           wr_full,
  output logic [5:0]     fifo_count,
  output logic           overflow,
  input  logic           start,
  input  logic [2:0]     start_instruction,
  output logic           busy,
  output logic           done,
  output logic           valid_instruction,
  output logic [2:0]     instruction,
  output logic [5:0]     data_size,
  output logic           valid_data,
  output logic [OPW-1:0] mc_data_in_opa,
  output logic [OPW-1:0] mc_data_in_opb
);

  localparam logic [2:0] LEAD_LAST = 3'(LEAD - 1);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] lead_cnt;
  logic [5:0] beat_cnt;
  logic       accept;
  logic       pop;
  logic       empty;
  pair_t      head;
  pair_t      wr_pair;

  assign wr_pair = '{opa: wr_opa, opb: wr_opb};

  simd_pair_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (wr_en),
    .push_data(wr_pair),
    .pop      (pop),
    .pop_data (head),
    .full     (wr_full),
    .empty    (empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Pops happen on the edge entering each beat so data and valid_data align.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    pop       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start && fifo_count != 6'd0) begin
          accept    = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (lead_cnt == LEAD_LAST) begin
          pop       = !empty;
          state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        if (beat_cnt == data_size - 6'd1) state_nxt = S_FINISH;
        else                               pop = !empty;
      end
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lead_cnt       <= '0;
      beat_cnt       <= '0;
      instruction    <= '0;
      data_size      <= '0;
      overflow       <= 1'b0;
      mc_data_in_opa <= '0;
      mc_data_in_opb <= '0;
    end else begin
      if (accept) begin
        instruction <= start_instruction;
        data_size   <= fifo_count;
      end
      lead_cnt <= (state == S_ISSUE)  ? lead_cnt + 3'd1 : 3'd0;
      beat_cnt <= (state == S_STREAM) ? beat_cnt + 6'd1 : 6'd0;
      if (wr_en && wr_full) overflow <= 1'b1;
      mc_data_in_opa <= pop ? head.opa : '0;
      mc_data_in_opb <= pop ? head.opb : '0;
    end
  end

  assign busy              = (state != S_IDLE);
  assign done              = (state == S_FINISH);
  assign valid_data        = (state == S_STREAM);
  assign valid_instruction = (state == S_ISSUE) || (state == S_STREAM);

endmodule

// File: tb/tb_simd_mc_feeder.sv
// Self-checking bench for simd_mc_feeder against a queue-based FIFO model.
// Directed scenarios with random operand data and opcodes.
module tb_simd_mc_feeder;

  localparam int DEPTH = 32;
  localparam int LEAD  = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         wr_en;
  logic [127:0] wr_opa;
  logic [127:0] wr_opb;
  logic         wr_full;
  logic [5:0]   fifo_count;
  logic         overflow;
  logic         start;
  logic [2:0]   start_instruction;
  logic         busy;
  logic         done;
  logic         valid_instruction;
  logic [2:0]   instruction;
  logic [5:0]   data_size;
  logic         valid_data;
  logic [127:0] mc_data_in_opa;
  logic [127:0] mc_data_in_opb;

  int checks = 0;
  int errors = 0;
  logic [255:0] model_q[$];
  logic         model_ovf;

  simd_mc_feeder #(.DEPTH(DEPTH), .LEAD(LEAD)) dut (
    .clk              (clk),
    .reset            (reset),
    .wr_en            (wr_en),
    .wr_opa           (wr_opa),
    .wr_opb           (wr_opb),
    .wr_full          (wr_full),
    .fifo_count       (fifo_count),
    .overflow         (overflow),
    .start            (start),
    .start_instruction(start_instruction),
    .busy             (busy),
    .done             (done),
    .valid_instruction(valid_instruction),
    .instruction      (instruction),
    .data_size        (data_size),
    .valid_data       (valid_data),
    .mc_data_in_opa   (mc_data_in_opa),
    .mc_data_in_opb   (mc_data_in_opb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
  endtask

  task automatic push(input logic [127:0] a, input logic [127:0] b);
    wr_en  = 1'b1;
    wr_opa = a;
    wr_opb = b;
    if (model_q.size() < DEPTH) model_q.push_back({a, b});
    else                        model_ovf = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_vi"}, valid_instruction, 0);
    check({tag, "_vd"}, valid_data, 0);
    check({tag, "_instr"}, instruction, 0);
    check({tag, "_dsize"}, data_size, 0);
    check({tag, "_opa"}, mc_data_in_opa, 0);
    check({tag, "_opb"}, mc_data_in_opb, 0);
    check({tag, "_count"}, fifo_count, 0);
    check({tag, "_full"}, wr_full, 0);
    check({tag, "_ovf"}, overflow, 0);
  endtask

  task automatic run_burst(input logic [2:0] op, input int mid);
    int n, lead, beats, pushed, rest;
    logic [255:0] exp;
    n = model_q.size();
    start = 1'b1;
    start_instruction = op;
    @(negedge clk);
    start = 1'b0;
    start_instruction = $urandom;
    check("busy_on", busy, 1);
    check("instr", instruction, op);
    check("dsize", data_size, n);
    lead = 0;
    for (int i = 0; i < 20 && !valid_data; i++) begin
      if (valid_instruction) lead++;
      @(negedge clk);
    end
    check("lead", lead, LEAD);
    beats = 0;
    pushed = 0;
    for (int i = 0; i < 40 && valid_data; i++) begin
      exp = (model_q.size() > 0) ? model_q.pop_front() : '0;
      check("beat_opa", mc_data_in_opa, exp[255:128]);
      check("beat_opb", mc_data_in_opb, exp[127:0]);
      check("vi_stream", valid_instruction, 1);
      if (pushed < mid && beats >= 1) begin
        wr_en  = 1'b1;
        wr_opa = rnd128();
        wr_opb = rnd128();
        model_q.push_back({wr_opa, wr_opb});
        pushed++;
      end else begin
        wr_en = 1'b0;
      end
      beats++;
      @(negedge clk);
    end
    wr_en = 1'b0;
    rest = model_q.size();
    check("beats", beats, n);
    check("done", done, 1);
    check("vi_finish", valid_instruction, 0);
    check("opa_idle", mc_data_in_opa, 0);
    @(negedge clk);
    check("done_once", done, 0);
    check("busy_off", busy, 0);
    check("count_after", fifo_count, rest);
    check("instr_hold", instruction, op);
  endtask

  initial begin
    logic [2:0] op;
    int seen;
    logic [255:0] exp;
    reset = 1'b1;
    wr_en = 1'b0;
    wr_opa = '0;
    wr_opb = '0;
    start = 1'b0;
    start_instruction = '0;
    model_ovf = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Basic burst of 14 pairs.
    push(128'h11111111_22222222_55555555_66666666, rnd128());
    for (int i = 1; i < 14; i++) push(rnd128(), rnd128());
    check("count14", fifo_count, 14);
    run_burst(3'b101, 0);

    // Fill past capacity.
    for (int i = 0; i < 33; i++) push(rnd128(), rnd128());
    check("full", wr_full, 1);
    check("count32", fifo_count, DEPTH);
    check("ovf", overflow, model_ovf);
    run_burst(3'b010, 0);
    check("ovf_sticky", overflow, 1);
    check("not_full", wr_full, 0);
    do_reset();
    check("ovf_cleared", overflow, 0);

    // Pushes during STREAM stay for the next burst.
    for (int i = 0; i < 4; i++) push(rnd128(), rnd128());
    run_burst(3'b011, 3);
    check("mid_count3", fifo_count, 3);
    run_burst(3'b110, 0);

    // Start with an empty FIFO is ignored.
    start = 1'b1;
    start_instruction = 3'b111;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (busy || valid_instruction || done) seen++;
      @(negedge clk);
    end
    check("empty_start", seen, 0);
    check("empty_instr", instruction, 3'b110);

    // Reset during beat 5 of a 10-beat burst.
    for (int i = 0; i < 10; i++) push(rnd128(), rnd128());
    start = 1'b1;
    start_instruction = 3'b001;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && !valid_data; i++) @(negedge clk);
    for (int b = 0; b < 5; b++) begin
      exp = model_q.pop_front();
      check("rst_beat", {mc_data_in_opa, mc_data_in_opb}, exp);
      if (b < 4) @(negedge clk);
    end
    do_reset();
    check_outputs_zero("midrst");
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (done || busy) seen++;
      @(negedge clk);
    end
    check("midrst_quiet", seen, 0);

    // Three 20-pair bursts cross the pointer wrap.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 20; i++) push(rnd128(), rnd128());
      op = 3'($urandom_range(0, 7));
      run_burst(op, 0);
    end

    // Start while busy is ignored.
    for (int i = 0; i < 3; i++) push(rnd128(), rnd128());
    start = 1'b1;
    start_instruction = 3'b100;
    @(negedge clk);
    start_instruction = 3'b011;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_instr", instruction, 3'b100);
    check("busy_start_dsize", data_size, 3);
    repeat (10) @(negedge clk);
    check("busy_start_idle", busy, 0);
    check("busy_start_count", fifo_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
